// File: rtl/axis_pkt_source.sv
// Stream packet source: emits pkt_len beats of incrementing payload starting at seed,
// honours m_ready backpressure, then optionally idles ifg cycles before accepting a new start.
module axis_pkt_source #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [3:0]            ifg,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  // state | meaning
  // IDLE  | waiting for start, no beats
  // SEND  | m_valid high, streaming beats
  // GAP   | inter-frame idle, counting down ifg
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] idx;
  logic [LEN_WIDTH-1:0] last_idx;
  logic [LEN_WIDTH-1:0] idx_nxt;
  logic [3:0]           ifg_q;
  logic [3:0]           gap_cnt;

  assign idx_nxt = idx + LEN_ONE;

  // m_data doubles as the payload accumulator, so the seed needs no separate copy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      last_idx  <= '0;
      ifg_q     <= '0;
      gap_cnt   <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      pkt_count <= '0;
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (pkt_len != '0) begin
              idx      <= '0;
              last_idx <= pkt_len - LEN_ONE;
              ifg_q    <= ifg;
              m_data   <= seed;
              m_valid  <= 1'b1;
              m_last   <= (pkt_len == LEN_ONE);
              busy     <= 1'b1;
              state    <= S_SEND;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (m_ready) begin
            if (m_last) begin
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              done      <= 1'b1;
              pkt_count <= pkt_count + CNT_ONE;
              if (ifg_q == 4'd0) begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                gap_cnt <= ifg_q;
                state   <= S_GAP;
              end
            end else begin
              idx    <= idx_nxt;
              m_data <= m_data + DATA_ONE;
              m_last <= (idx_nxt == last_idx);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd1) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_source.sv
// Bench for axis_pkt_source: expected payload queues built from seed+k, random backpressure,
// gap timing, length-error pulse, mid-packet reset and long packets.
module tb_axis_pkt_source;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [11:0] pkt_len;
  logic [7:0]  seed;
  logic [3:0]  ifg;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic        len_err;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  axis_pkt_source dut (
    .clk(clk), .resetn(resetn), .start(start), .pkt_len(pkt_len), .seed(seed), .ifg(ifg),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .len_err(len_err), .pkt_count(pkt_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // mode 0: always ready, 1: random, 2: repeating 1,0,0
  function automatic logic pick_ready(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 2) return (n % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic send_pkt(input int len, input logic [7:0] sd, input logic [3:0] g,
                          input int mode, input bit gap_start);
    logic [7:0] exp_q[$];
    int k;
    int cyc;
    int n;
    exp_q = {};
    for (int i = 0; i < len; i++) exp_q.push_back(8'(int'(sd) + i));
    @(negedge clk);
    start = 1'b1; pkt_len = len[11:0]; seed = sd; ifg = g;
    m_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0; pkt_len = 12'($urandom); seed = 8'($urandom); ifg = 4'($urandom);
    k = 0; cyc = 0; n = 0;
    while (k < len && cyc < len * 8 + 64) begin
      chk("valid", m_valid, 1);
      chk("data", m_data, exp_q[k]);
      chk("last", m_last, k == len - 1);
      chk("busy_send", busy, 1);
      chk("done_send", done, 0);
      m_ready = pick_ready(mode, n);
      n++;
      if (m_ready) k++;
      @(negedge clk);
      cyc++;
    end
    chk("handshakes", k, len);
    if (mode == 0) chk("beat_cycles", cyc, len);
    exp_count++;
    m_ready = 1'($urandom_range(0, 1));
    chk("done", done, 1);
    chk("valid_after", m_valid, 0);
    chk("last_after", m_last, 0);
    chk("count", pkt_count, 16'(exp_count));
    chk("busy_done", busy, g != 4'd0);
    for (int j = 1; j <= int'(g); j++) begin
      if (j > 1) begin
        @(negedge clk);
        chk("gap_busy", busy, 1);
        chk("gap_valid", m_valid, 0);
        chk("gap_len_err", len_err, 0);
        chk("gap_done", done, 0);
      end
      start = gap_start && (j < int'(g));
      pkt_len = 12'd0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", m_valid, 0);
    chk("idle_done", done, 0);
    chk("idle_len_err", len_err, 0);
  endtask

  initial begin
    logic [7:0] sd;
    resetn = 1'b0; start = 1'b0; pkt_len = '0; seed = '0; ifg = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_count", pkt_count, 0);
    resetn = 1'b1;

    send_pkt(4, 8'h10, 4'd0, 0, 1'b0);
    send_pkt(5, 8'hFE, 4'd0, 2, 1'b0);
    send_pkt(1, 8'hAA, 4'd3, 1, 1'b1);
    send_pkt(2, 8'h33, 4'd1, 1, 1'b0);

    @(negedge clk);
    start = 1'b1; pkt_len = 12'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len_err_pulse", len_err, 1);
    chk("len_err_valid", m_valid, 0);
    chk("len_err_busy", busy, 0);
    @(negedge clk);
    chk("len_err_clear", len_err, 0);
    chk("len_err_valid2", m_valid, 0);
    chk("len_err_count", pkt_count, 16'(exp_count));

    sd = 8'($urandom);
    start = 1'b1; pkt_len = 12'd8; seed = sd; ifg = 4'd0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_data", m_data, 8'(sd + 8'd2));
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_last", m_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", m_data, 0);
    chk("arst_count", pkt_count, 0);
    @(negedge clk);
    resetn = 1'b1;
    exp_count = 0;
    send_pkt(3, 8'($urandom), 4'd0, 1, 1'b0);

    for (int r = 0; r < 4; r++)
      send_pkt($urandom_range(1, 20), 8'($urandom), 4'($urandom_range(0, 5)), 1,
               $urandom_range(0, 1) == 1);

    send_pkt(10, 8'($urandom), 4'd0, 1, 1'b0);
    send_pkt(4095, 8'($urandom), 4'd0, 1, 1'b0);
    send_pkt(2047, 8'($urandom), 4'd2, 1, 1'b0);
    send_pkt(1, 8'($urandom), 4'd0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_pkt_source.md
Name: axis_pkt_source

Overview:
Stream packet transmitter that drives the slave-side stream port (s_data/s_valid/s_last, s_ready) of the team's stream FIFOs.
On a start command it emits a framed packet of pkt_len beats with an incrementing-byte payload, asserts last on the final beat, and fully honours ready backpressure.
It is used as the traffic source for FIFO bring-up and as the producer stage in stream datapaths.
It also reports a packet count and a completion pulse for the control side.

Parameters:
DATA_WIDTH, 8, width of m_data; payload arithmetic is modulo 2^DATA_WIDTH
LEN_WIDTH, 12, width of pkt_len; maximum packet is 2^LEN_WIDTH-1 beats
CNT_WIDTH, 16, width of pkt_count

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  asynchronous, active-low reset
start  input  1  request a packet; sampled only in IDLE
pkt_len  input  LEN_WIDTH  beats in packet; latched with start
seed  input  DATA_WIDTH  first payload value; latched with start
ifg  input  4  idle cycles inserted after a packet; latched with start
m_data  output  DATA_WIDTH  stream payload
m_valid  output  1  beat valid
m_last  output  1  final beat of packet
m_ready  input  1  downstream ready
busy  output  1  high in SEND or GAP
done  output  1  one-cycle pulse after final handshake
len_err  output  1  one-cycle pulse when start is seen with pkt_len==0
pkt_count  output  CNT_WIDTH  completed packets, wraps

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): state=IDLE; m_data=0, m_valid=0, m_last=0, busy=0, done=0, len_err=0, pkt_count=0.
- Reset asserted mid-packet: outputs clear immediately. No m_last is emitted. pkt_count is not incremented.
- All outputs are registered. No combinational path from m_ready to m_valid or m_data.
- Handshake: a beat transfers on a rising edge with m_valid && m_ready.
- Once m_valid=1, m_data, m_valid and m_last stay stable until that handshake. m_valid never drops without a handshake.
- FSM IDLE:
  - start && pkt_len!=0: latch len, seed and ifg. Clear the beat index. Next cycle: SEND, m_valid=1, m_data=seed, m_last=(len==1), busy=1.
  - start && pkt_len==0: len_err=1 for one cycle, remain IDLE, no beats.
- FSM SEND:
  - On each handshake of beat i (0-based) with i<len-1: next m_data=seed+i+1 (mod 2^DATA_WIDTH), m_last=(i+1==len-1).
  - On the handshake of beat len-1 (m_last=1): m_valid=0 and m_last=0 next cycle, done=1 for one cycle, pkt_count+=1.
  - Then if ifg==0 go to IDLE, else load the gap counter with ifg and go to GAP.
- FSM GAP: decrement the counter each cycle; at 1, go to IDLE. Gap length is exactly ifg cycles with m_valid=0.
- busy is high from the cycle after start is accepted through the last GAP cycle. It is low in the cycle done pulses if ifg==0.
- start while busy is ignored: no latch, no error.
- Back-to-back: with ifg=0, start held high gives a minimum of 1 idle cycle (IDLE state) between m_last handshake and the next first beat.
- Beat index and length compare at LEN_WIDTH bits. pkt_len=2^LEN_WIDTH-1 must complete correctly.
- pkt_count wraps from 2^CNT_WIDTH-1 to 0.
- m_ready is ignored outside SEND.

Test Plan:
- Reset then start with pkt_len=4, seed=0x10, ifg=0, m_ready=1 -> beats 0x10,0x11,0x12,0x13 on 4 consecutive cycles; m_last only on 0x13; done pulses the next cycle; pkt_count=1.
- pkt_len=5, seed=0xFE, m_ready toggling 1,0,0,1,... -> data 0xFE,0xFF,0x00,0x01,0x02 with wrap; each beat held stable while m_ready=0; exactly 5 handshakes; m_last on 0x02 only.
- pkt_len=1, seed=0xAA, ifg=3 -> single beat 0xAA with m_last=1; then 3 cycles busy=1 and m_valid=0; start during the gap ignored; next start accepted in IDLE.
- start with pkt_len=0 -> len_err one-cycle pulse; m_valid stays 0; pkt_count unchanged.
- resetn asserted low after beat 2 of a pkt_len=8 packet -> m_valid/m_last/busy drop asynchronously; pkt_count=0; after release a fresh pkt_len=3 packet starts from its seed.
- Connected to a 2048-deep stream FIFO: 3 packets of lengths 10, 2047 and 1 -> FIFO output reproduces every byte in order; pkt_count=3; no beat lost or duplicated under random m_ready.
